fir_tap_sequencer: RTL and testbench

Sequencer for the 2D FIR partial-product datapath: it takes one 3x3 pixel window and its coefficient kernel and sequences the shared 12-bit NOR partial-product cell bit-serially over every tap and coefficient bit. It shift-accumulates each returned partial product into a single filter output sample. It sits between the window/line-buffer stage (upstream) and the output formatter (downstream), and owns the one NOR cell instance.

---
 rtl/fir_tap_sequencer.sv | 95 +++++++++
 tb/tb_fir_tap_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: bit-serial 3x3 FIR sequencer driving an external NOR partial-product cell
//   in_valid/in_ready, pix_in, coef_in : window + kernel handshake from the line-buffer stage
//   pp_shifted, pp_kill, pp_in         : NOR cell operand, kill and combinational return
//   out_valid/out_ready, result        : filter sum handshake to the output formatter
//   busy, tap_idx, bit_idx             : sequencing status for debug
module fir_tap_sequencer #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 4,
  parameter int TAPS   = 9,
  parameter int ACC_W  = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAPS*DATA_W-1:0]     pix_in,
  input  logic [TAPS*COEF_W-1:0]     coef_in,
  output logic [DATA_W-1:0]          pp_shifted,
  output logic                       pp_kill,
  input  logic [DATA_W-1:0]          pp_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           result,
  output logic                       busy,
  output logic [3:0]                 tap_idx,
  output logic [$clog2(COEF_W)-1:0]  bit_idx
);
  localparam int BW = $clog2(COEF_W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [TAPS*DATA_W-1:0] pix_q, pix_d;
  logic [TAPS*COEF_W-1:0] coef_q, coef_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0] tap_q, tap_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] pix_w [TAPS];
  logic [COEF_W-1:0] coef_w [TAPS];
  logic bit_last, last, run;
  for (genvar t = 0; t < TAPS; t++) begin : g_view
    assign pix_w[t]  = pix_q[t*DATA_W +: DATA_W];
    assign coef_w[t] = coef_q[t*COEF_W +: COEF_W];
  end
  assign run      = state_q == RUN;
  assign bit_last = bit_q == BW'(COEF_W-1);
  assign last     = bit_last && tap_q == 4'(TAPS-1);
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    tap_d   = tap_q;
    bit_d   = bit_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      pix_d   = pix_in;
      coef_d  = coef_in;
      acc_d   = '0;
      tap_d   = '0;
      bit_d   = '0;
    end else if (run) begin
      acc_d   = acc_q + (ACC_W'(pp_in) << bit_q);
      bit_d   = bit_last ? '0 : bit_q + 1'b1;
      tap_d   = last ? '0 : bit_last ? tap_q + 4'd1 : tap_q;
      state_d = last ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pix_q   <= '0;
      coef_q  <= '0;
      acc_q   <= '0;
      tap_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      coef_q  <= coef_d;
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      bit_q   <= bit_d;
    end
  end
  // NOR cell as AND: ~(~pix | ~bit) = pix & bit; outside RUN both inputs force 0
  assign pp_shifted = run ? ~pix_w[tap_q] : '1;
  assign pp_kill    = run ? ~coef_w[tap_q][bit_q] : 1'b1;
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign result     = acc_q;
  assign tap_idx    = tap_q;
  assign bit_idx    = bit_q;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed self-checking bench with a behavioural NOR cell
module tb_fir_tap_sequencer;
  localparam int DW = 12, CW = 4, T = 9, AW = 20;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, pp_kill, out_valid, out_ready, busy;
  logic [T*DW-1:0] pix_in;
  logic [T*CW-1:0] coef_in;
  logic [DW-1:0] pp_shifted, pp_in;
  logic [AW-1:0] result;
  logic [3:0] tap_idx;
  logic [1:0] bit_idx;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign pp_in = ~(pp_shifted | {DW{pp_kill}});
  fir_tap_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pix_in(pix_in), .coef_in(coef_in), .pp_shifted(pp_shifted), .pp_kill(pp_kill),
    .pp_in(pp_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .busy(busy), .tap_idx(tap_idx), .bit_idx(bit_idx)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [T*DW-1:0] pix_seq();
    logic [T*DW-1:0] v;
    for (int i = 0; i < T; i++) v[i*DW +: DW] = DW'(i + 1);
    return v;
  endfunction
  function automatic logic [T*CW-1:0] coef_all(input logic [CW-1:0] c);
    logic [T*CW-1:0] v;
    for (int i = 0; i < T; i++) v[i*CW +: CW] = c;
    return v;
  endfunction
  task automatic load(input logic [T*DW-1:0] p, input logic [T*CW-1:0] c);
    pix_in = p;
    coef_in = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    pix_in = '0;
    coef_in = '0;
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, busy, pp_kill} !== 4'b1001)
      begin errors++; $display("FAIL reset_flags: got %b want 1001", {in_ready, out_valid, busy, pp_kill}); end
    checks++;
    if ({tap_idx, bit_idx, pp_shifted, result} !== {4'd0, 2'd0, 12'hFFF, 20'd0})
      begin errors++; $display("FAIL reset_vals: tap %0d bit %0d shifted %h result %0d", tap_idx, bit_idx, pp_shifted, result); end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL post_reset_idle: in_ready %b busy %b want 1 0", in_ready, busy); end
  endtask
  task automatic test_ones();
    logic [DW-1:0] exp;
    out_ready = 1'b1;
    load(pix_seq(), coef_all(4'd1));
    for (int c = 1; c <= 36; c++) begin
      exp = ((c - 1) % 4 == 0) ? DW'((c - 1) / 4 + 1) : '0;
      checks++;
      if (pp_in !== exp || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1)
        begin errors++; $display("FAIL ones_run c%0d: pp_in %0d ov %b ir %b busy %b want %0d 0 0 1", c, pp_in, out_valid, in_ready, busy, exp); end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || result !== 20'd45)
      begin errors++; $display("FAIL ones_result: out_valid %b result %0d want 1 45", out_valid, result); end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL ones_idle38: ir %b ov %b busy %b want 1 0 0", in_ready, out_valid, busy); end
  endtask
  task automatic test_max();
    logic [T*DW-1:0] p;
    p = '1;
    load(p, coef_all(4'hF));
    for (int c = 1; c <= 36; c++) tick();
    checks++;
    if (out_valid !== 1'b1 || result !== 20'd552825)
      begin errors++; $display("FAIL max_result: out_valid %b result %0d want 1 552825", out_valid, result); end
    tick();
  endtask
  task automatic test_zero_coef();
    logic [T*DW-1:0] p;
    for (int i = 0; i < T; i++) p[i*DW +: DW] = DW'($urandom_range(1, 4095));
    load(p, '0);
    for (int c = 1; c <= 36; c++) begin
      checks++;
      if (pp_in !== '0 || out_valid !== 1'b0)
        begin errors++; $display("FAIL zero_run c%0d: pp_in %0d ov %b want 0 0", c, pp_in, out_valid); end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || result !== '0)
      begin errors++; $display("FAIL zero_result: out_valid %b result %0d want 1 0", out_valid, result); end
    tick();
  endtask
  task automatic test_single_tap();
    logic [T*DW-1:0] p;
    logic [T*CW-1:0] k;
    logic [3:0] et;
    logic [1:0] eb;
    logic [DW-1:0] ep;
    p = '0;
    k = '0;
    p[4*DW +: DW] = 12'd100;
    k[4*CW +: CW] = 4'b1010;
    load(p, k);
    for (int c = 1; c <= 36; c++) begin
      et = 4'((c - 1) / 4);
      eb = 2'((c - 1) % 4);
      ep = (et == 4'd4 && (eb == 2'd1 || eb == 2'd3)) ? 12'd100 : 12'd0;
      checks++;
      if (tap_idx !== et || bit_idx !== eb || pp_in !== ep)
        begin errors++; $display("FAIL single_step c%0d: tap %0d bit %0d pp %0d want %0d %0d %0d", c, tap_idx, bit_idx, pp_in, et, eb, ep); end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || result !== 20'd1000)
      begin errors++; $display("FAIL single_result: out_valid %b result %0d want 1 1000", out_valid, result); end
    tick();
  endtask
  task automatic test_backpressure();
    out_ready = 1'b0;
    load(pix_seq(), coef_all(4'd3));
    for (int c = 1; c <= 36; c++) begin
      in_valid = (c % 7 == 0);
      pix_in = '1;
      coef_in = '1;
      checks++;
      if (in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_run_ready c%0d: in_ready %b want 0", c, in_ready); end
      tick();
    end
    for (int d = 0; d < 5; d++) begin
      in_valid = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || result !== 20'd135 || in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold d%0d: ov %b result %0d ir %b want 1 135 0", d, out_valid, result, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || result !== 20'd135)
      begin errors++; $display("FAIL bp_release: ov %b result %0d want 1 135", out_valid, result); end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL bp_idle: ir %b ov %b want 1 0", in_ready, out_valid); end
  endtask
  task automatic test_reset_mid_run();
    load(pix_seq(), coef_all(4'd1));
    for (int c = 1; c <= 10; c++) tick();
    checks++;
    if (tap_idx !== 4'd2 || bit_idx !== 2'd2 || busy !== 1'b1)
      begin errors++; $display("FAIL rmid_pos: tap %0d bit %0d busy %b want 2 2 1", tap_idx, bit_idx, busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, pp_kill, busy} !== 4'b1010)
      begin errors++; $display("FAIL rmid_async: ir/ov/kill/busy %b want 1010", {in_ready, out_valid, pp_kill, busy}); end
    #1;
    rst = 1'b0;
    tick();
    load(pix_seq(), coef_all(4'd2));
    for (int c = 1; c <= 36; c++) tick();
    checks++;
    if (out_valid !== 1'b1 || result !== 20'd90)
      begin errors++; $display("FAIL rmid_result: out_valid %b result %0d want 1 90", out_valid, result); end
    tick();
    checks++;
    if (in_ready !== 1'b1)
      begin errors++; $display("FAIL rmid_idle: in_ready %b want 1", in_ready); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: timeout after %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_ones();
    test_max();
    test_zero_coef();
    test_single_tap();
    test_backpressure();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
